msj_serializer: RTL
===================

// Module: msj_serializer
// PURPOSE
//   Transmit side of the serial message line M consumed by the FSM receiver.
//   Accepts an 8-bit message word over a valid/ready handshake.
//   Emits the word on M as a framed serial bit stream: start bit, data MSB-first, stop bit.
//   Sits between the message source (control logic or switches) and the M input of the receiver.
// PARAMETERS
//   DATA_W      8   message width in bits; msj_d width and data-bit count per frame
//   BIT_CYCLES  1   clock cycles each bit is held on M; legal range 1..255
// PORTS
//   clk        in   1       single system clock; all state updates on rising edge
//   rst        in   1       asynchronous reset, active-low (0 = reset)
//   msj_d      in   DATA_W  message word to transmit
//   msj_valid  in   1       msj_d is valid and requests transmission
//   msj_ready  out  1       serializer can accept a word this cycle
//   M          out  1       serial output line, registered
//   busy       out  1       frame in progress (any state other than IDLE)
//   done       out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, M=0, busy=0, done=0, msj_ready=1.
//     Shift register and bit/cycle counters clear to 0.
//   Line idle level is 0. Start bit = 1. Stop bit = 0.
//   States:
//     IDLE  -> START  on msj_valid & msj_ready
//     START -> DATA   after BIT_CYCLES clocks
//     DATA  -> STOP   after DATA_W bits x BIT_CYCLES clocks each
//     STOP  -> IDLE   after BIT_CYCLES clocks
//   Accept:
//     msj_ready = 1 only in IDLE (combinational from state).
//     A transfer happens on the edge where msj_valid & msj_ready = 1.
//     At that edge msj_d is latched into the shift register and M <= 1.
//   Hold timing:
//     cyc_cnt counts 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary.
//     bit_cnt counts data bits 0..DATA_W-1.
//   Data: on each data-bit boundary M <= shreg[DATA_W-1] and shreg shifts left by 1.
//     Bits go out MSB first.
//   STOP: M <= 0 for BIT_CYCLES clocks.
//     On the exit edge: done <= 1 for exactly one cycle, state <= IDLE.
//   Frame length: (DATA_W+2)*BIT_CYCLES cycles from the accept edge to re-entry into IDLE.
//   Back-to-back (msj_valid held high): next accept occurs on the first IDLE cycle.
//     M stays 0 for exactly 1 cycle between frames.
//   msj_valid or msj_d changes while busy: ignored. The latched word is unaffected.
//   done and the accept of a new word may occur on consecutive cycles, never on the same cycle.
//   Reset mid-frame: frame is aborted immediately. M=0, no done pulse, IDLE.
//   Counters never exceed their terminal values; wrap only via state transition.
// TESTING
//   1 Reset: rst=0 with msj_valid=1 -> M=0, msj_ready=1, busy=0, done=0; nothing accepted.
//   2 DATA_W=8, BIT_CYCLES=1, send 8'hA5 -> M on the 10 cycles after accept is
//     1,1,0,1,0,0,1,0,1,0; done pulses once; msj_ready=1 on the 11th cycle.
//   3 BIT_CYCLES=3, send 8'h81 -> each bit held 3 cycles; 30-cycle frame;
//     M = 1x3, 1x3, 0x18, 1x3, 0x3.
//   4 Send 8'h00 -> start bit is the only 1 on M; done still pulses after 10 cycles.
//   5 Change msj_d to 8'hFF mid-frame with msj_valid=1 -> serial output still carries
//     the original word; 8'hFF is accepted only after done, with a 1-cycle idle gap.
//   6 Drive rst=0 during data bit 4 of 8'h5A -> M=0 asynchronously, no done pulse;
//     after release, a new 8'h3C frame transmits correctly.

Source files
------------

// File: rtl/msj_serializer.sv
// -----------------------------------------------------------------------------
// msj_serializer
//   Transmit side of the serial message line M. Takes one DATA_W-bit word over
//   a valid/ready handshake and sends it as a framed serial stream:
//   start bit (1), data bits MSB first, stop bit (0). The line idles at 0.
//   Each bit is held on M for BIT_CYCLES clocks.
//
// Parameters
//   DATA_W      message width in bits (>= 2)
//   BIT_CYCLES  clocks per bit on M, 1..255
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   msj_d      in   message word to transmit
//   msj_valid  in   msj_d is valid and requests transmission
//   msj_ready  out  high only in IDLE; a word is taken when valid & ready
//   M          out  serial line (registered)
//   busy       out  frame in progress (registered)
//   done       out  one-cycle pulse on the clock after the stop bit ends
// -----------------------------------------------------------------------------
module msj_serializer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] msj_d,
  input  logic              msj_valid,
  output logic              msj_ready,
  output logic              M,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]       CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  shreg_r;
  logic [7:0]         cyc_cnt_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic               m_r;
  logic               busy_r;
  logic               done_r;

  logic               accept_s;
  logic               cyc_last_s;

  // Left shift of the data register, zero fill at the LSB.
  function automatic logic [DATA_W-1:0] shift_left(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], 1'b0};
  endfunction

  // Ready is a pure decode of the state register so it is glitch-free.
  assign msj_ready  = (state_r == ST_IDLE);
  assign accept_s   = msj_valid & msj_ready;
  assign cyc_last_s = (cyc_cnt_r == CYC_LAST);

  assign M    = m_r;
  assign busy = busy_r;
  assign done = done_r;

  // Frame sequencer: state, shift register, hold counters and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      cyc_cnt_r <= 8'd0;
      bit_cnt_r <= '0;
      m_r       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // Latch the word and drive the start bit on the accept edge.
            shreg_r   <= msj_d;
            m_r       <= 1'b1;
            busy_r    <= 1'b1;
            cyc_cnt_r <= 8'd0;
            bit_cnt_r <= '0;
            state_r   <= ST_START;
          end else begin
            m_r    <= 1'b0;
            busy_r <= 1'b0;
          end
        end

        ST_START: begin
          if (cyc_last_s) begin
            cyc_cnt_r <= 8'd0;
            bit_cnt_r <= '0;
            m_r       <= shreg_r[DATA_W-1];
            shreg_r   <= shift_left(shreg_r);
            state_r   <= ST_DATA;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
          end
        end

        ST_DATA: begin
          if (cyc_last_s) begin
            cyc_cnt_r <= 8'd0;
            if (bit_cnt_r == BIT_LAST) begin
              // Last data bit finished: drive the stop bit.
              bit_cnt_r <= '0;
              m_r       <= 1'b0;
              state_r   <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              m_r       <= shreg_r[DATA_W-1];
              shreg_r   <= shift_left(shreg_r);
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
          end
        end

        ST_STOP: begin
          if (cyc_last_s) begin
            cyc_cnt_r <= 8'd0;
            m_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          cyc_cnt_r <= 8'd0;
          bit_cnt_r <= '0;
          m_r       <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
